// File: rtl/tmds_link_sequencer.sv
// TMDS link start-up/shutdown sequencer ahead of the OSER10 bank: lock qualify, serializer reset, preamble, run.
// Latency: 1 cycle on every input-to-output path; no backpressure, words pass through unconditionally in RUN.
module tmds_link_sequencer #(
  parameter int NUM_CHANNELS    = 3,
  parameter int LOCK_CYCLES     = 1024,
  parameter int RST_CYCLES      = 16,
  parameter int PREAMBLE_CYCLES = 64
) (
  input  logic                         clk_pixel,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         hpd,
  input  logic                         pll_lock,
  input  logic                         frame_start,
  input  logic                         hsync,
  input  logic                         vsync,
  input  logic [NUM_CHANNELS-1:0][9:0] tmds_in,
  output logic [NUM_CHANNELS-1:0][9:0] tmds_internal,
  output logic                         ser_reset,
  output logic                         link_up,
  output logic [2:0]                   state_o
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int PW = $clog2(PREAMBLE_CYCLES + 1);

  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_SAT  = LW'(LOCK_CYCLES);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] PRE_SAT   = PW'(PREAMBLE_CYCLES);

  localparam logic [9:0] CTL00 = 10'b1101010100;
  localparam logic [9:0] CTL01 = 10'b0010101011;
  localparam logic [9:0] CTL10 = 10'b0101010100;
  localparam logic [9:0] CTL11 = 10'b1010101011;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOCK_WAIT = 3'd1,
    SER_RST   = 3'd2,
    PREAMBLE  = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   lock_cnt;
  logic [RW-1:0]   rst_cnt;
  logic [PW-1:0]   pre_cnt;
  logic            go;

  function automatic logic [9:0] ctl_sym(input logic c1, input logic c0);
    logic [9:0] sym;
    case ({c1, c0})
      2'b00:   sym = CTL00;
      2'b01:   sym = CTL01;
      2'b10:   sym = CTL10;
      default: sym = CTL11;
    endcase
    return sym;
  endfunction

  always_comb begin
    go        = enable & hpd & pll_lock;
    state_nxt = state;
    case (state)
      IDLE:      if (go) state_nxt = LOCK_WAIT;
      LOCK_WAIT: if (pll_lock && lock_cnt == LOCK_LAST) state_nxt = SER_RST;
      SER_RST:   if (rst_cnt == RST_LAST) state_nxt = PREAMBLE;
      PREAMBLE:  if (frame_start && pre_cnt == PRE_SAT) state_nxt = RUN;
      RUN:       state_nxt = RUN;
      default:   state_nxt = IDLE;
    endcase
    // Losing any of enable/hpd/lock outranks every forward transition.
    if (state != IDLE && !go) state_nxt = IDLE;
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      rst_cnt   <= '0;
      pre_cnt   <= '0;
      ser_reset <= 1'b1;
      link_up   <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) tmds_internal[i] <= CTL00;
    end else begin
      state <= state_nxt;

      // Counters only advance while remaining in their own state, so entry always starts from zero.
      if (state == LOCK_WAIT && state_nxt == LOCK_WAIT && pll_lock)
        lock_cnt <= (lock_cnt == LOCK_SAT) ? lock_cnt : lock_cnt + 1'b1;
      else
        lock_cnt <= '0;

      if (state == SER_RST && state_nxt == SER_RST)
        rst_cnt <= rst_cnt + 1'b1;
      else
        rst_cnt <= '0;

      if (state == PREAMBLE && state_nxt == PREAMBLE)
        pre_cnt <= (pre_cnt == PRE_SAT) ? pre_cnt : pre_cnt + 1'b1;
      else
        pre_cnt <= '0;

      ser_reset <= !(state_nxt == PREAMBLE || state_nxt == RUN);
      link_up   <= (state_nxt == RUN);

      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (state_nxt == RUN)
          tmds_internal[i] <= tmds_in[i];
        else if (i == 0)
          tmds_internal[i] <= ctl_sym(vsync, hsync);
        else
          tmds_internal[i] <= CTL00;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Bench for tmds_link_sequencer: directed bring-up/abort/reset scenarios followed by random traffic,
// checked against a model that tracks elapsed cycles since leaving IDLE.
module tb_tmds_link_sequencer;

  localparam int L = 8;
  localparam int R = 4;
  localparam int P = 6;

  localparam logic [9:0] CTL00 = 10'b1101010100;

  logic            clk_pixel = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            hpd = 1'b0;
  logic            pll_lock = 1'b0;
  logic            frame_start = 1'b0;
  logic            hsync = 1'b0;
  logic            vsync = 1'b0;
  logic [2:0][9:0] tmds_in = '0;
  logic [2:0][9:0] tmds_internal;
  logic            ser_reset;
  logic            link_up;
  logic [2:0]      state_o;

  int checks = 0;
  int errors = 0;

  logic [9:0] ctl_tab [4];

  // Model: active = out of IDLE, t = cycles since entering lock wait, running = in RUN.
  bit              m_active = 1'b0;
  bit              m_running = 1'b0;
  int              m_t = 0;
  logic [29:0]     m_tmds = '0;
  logic            m_ser = 1'b1;
  logic            m_up = 1'b0;
  int              m_state = 0;

  always #5 clk_pixel = ~clk_pixel;

  tmds_link_sequencer #(
    .NUM_CHANNELS(3),
    .LOCK_CYCLES(L),
    .RST_CYCLES(R),
    .PREAMBLE_CYCLES(P)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .enable(enable),
    .hpd(hpd),
    .pll_lock(pll_lock),
    .frame_start(frame_start),
    .hsync(hsync),
    .vsync(vsync),
    .tmds_in(tmds_in),
    .tmds_internal(tmds_internal),
    .ser_reset(ser_reset),
    .link_up(link_up),
    .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int en, input int hp, input int lk, input int fs,
                      input int hs, input int vs, input int rn, input logic [29:0] w);
    bit go;
    enable      = (en != 0);
    hpd         = (hp != 0);
    pll_lock    = (lk != 0);
    frame_start = (fs != 0);
    hsync       = (hs != 0);
    vsync       = (vs != 0);
    reset_n     = (rn != 0);
    tmds_in     = w;
    @(posedge clk_pixel);
    if (rn == 0) begin
      m_active  = 1'b0;
      m_running = 1'b0;
      m_t       = 0;
      m_tmds    = {3{CTL00}};
    end else begin
      go = (en != 0) && (hp != 0) && (lk != 0);
      if (!m_active) begin
        if (go) begin
          m_active = 1'b1;
          m_t      = 0;
        end
      end else if (!go) begin
        m_active  = 1'b0;
        m_running = 1'b0;
      end else if (!m_running) begin
        if (fs != 0 && m_t >= L + R + P) m_running = 1'b1;
        else m_t++;
      end
      m_tmds = m_running ? w : {CTL00, CTL00, ctl_tab[{vs != 0, hs != 0}]};
    end
    m_up  = m_running;
    m_ser = !m_active || (!m_running && m_t < L + R);
    if (!m_active)          m_state = 0;
    else if (m_running)     m_state = 4;
    else if (m_t < L)       m_state = 1;
    else if (m_t < L + R)   m_state = 2;
    else                    m_state = 3;
    #1;
    chk("state_o", 32'(state_o), 32'(m_state));
    chk("ser_reset", 32'(ser_reset), 32'(m_ser));
    chk("link_up", 32'(link_up), 32'(m_up));
    chk("tmds_internal", 32'(tmds_internal), 32'(m_tmds));
  endtask

  initial begin
    int n;
    ctl_tab[0] = 10'b1101010100;
    ctl_tab[1] = 10'b0010101011;
    ctl_tab[2] = 10'b0101010100;
    ctl_tab[3] = 10'b1010101011;

    // Reset with go and sync levels active: lanes must still read CTL00.
    step(1, 1, 1, 0, 1, 1, 0, 30'($urandom));
    step(1, 1, 1, 0, 1, 1, 0, 30'($urandom));
    chk("reset_ser", 32'(ser_reset), 32'd1);
    chk("reset_lanes", 32'(tmds_internal), 32'({3{CTL00}}));

    // Bring-up with hsync=1, vsync=0.
    n = 0;
    for (int i = 0; i < 13; i++) begin
      step(1, 1, 1, 0, 1, 0, 1, 30'($urandom));
      if (ser_reset) n++;
    end
    chk("bringup_ser_cycles", 32'(n), 32'(L + R));
    chk("preamble_ser_low", 32'(ser_reset), 32'd0);
    chk("lane0_ctl01", 32'(tmds_internal[0]), 32'(10'b0010101011));
    chk("lane1_ctl00", 32'(tmds_internal[1]), 32'(10'b1101010100));
    chk("lane2_ctl00", 32'(tmds_internal[2]), 32'(10'b1101010100));

    // Early frame_start at preamble cycle 3, then a qualifying one six cycles later.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 1, 0, 1, 30'($urandom));
    step(1, 1, 1, 1, 1, 0, 1, 30'($urandom));
    chk("early_fs_ignored", 32'(link_up), 32'd0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 1, 0, 1, 30'($urandom));
    step(1, 1, 1, 1, 1, 0, 1, {3{10'h155}});
    chk("run_link_up", 32'(link_up), 32'd1);
    chk("run_first_word", 32'(tmds_internal), 32'({3{10'h155}}));
    for (int i = 0; i < 4; i++) step(1, 1, 1, $urandom_range(0, 1), 0, 0, 1, 30'($urandom));

    // Hot-plug drop in RUN.
    step(1, 0, 1, 0, 0, 1, 1, 30'($urandom));
    chk("hpd_drop_state", 32'(state_o), 32'd0);
    chk("hpd_drop_ser", 32'(ser_reset), 32'd1);
    chk("hpd_drop_lane0", 32'(tmds_internal[0]), 32'(10'b0101010100));

    // Lock glitch at lock_cnt=5, then a fresh 8-cycle qualification.
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0, 1, 30'($urandom));
    step(1, 1, 0, 0, 0, 0, 1, 30'($urandom));
    chk("glitch_abort", 32'(state_o), 32'd0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 0, 1, 30'($urandom));
    chk("glitch_still_lock_wait", 32'(state_o), 32'd1);
    step(1, 1, 1, 0, 0, 0, 1, 30'($urandom));
    chk("glitch_ser_rst", 32'(state_o), 32'd2);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 1, 1, 1, 30'($urandom));

    // Synchronous reset mid-preamble: level changes between edges must not act.
    reset_n = 1'b0;
    #2;
    chk("reset_no_edge", 32'(state_o), 32'd3);
    step(1, 1, 1, 0, 1, 1, 0, 30'($urandom));
    chk("sync_reset_state", 32'(state_o), 32'd0);
    reset_n = 1'b1;
    #2;
    chk("release_no_edge_state", 32'(state_o), 32'd0);
    chk("release_no_edge_ser", 32'(ser_reset), 32'd1);

    // enable low: parked in IDLE regardless of frame_start.
    for (int i = 0; i < 40; i++)
      step(0, 1, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1, 30'($urandom));
    chk("disabled_idle", 32'(state_o), 32'd0);
    chk("disabled_ser", 32'(ser_reset), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step(int'($urandom_range(0, 99) != 0), int'($urandom_range(0, 99) != 0),
           int'($urandom_range(0, 99) != 0), int'($urandom_range(0, 5) == 0),
           $urandom_range(0, 1), $urandom_range(0, 1),
           int'($urandom_range(0, 499) != 0), 30'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
